// File: rtl/alu_ctrl_seq.sv
`default_nettype none
// ============================================================================
// alu_ctrl_seq: registered ALU-control decoder with MUL (and ALU_CTRL_DIV_EN DIV) sequencing.
// Rev 1.0
// ============================================================================
module alu_ctrl_seq #(
  parameter int FUNCT_W = 4,
  parameter int CTRL_W  = 4,
  parameter int MUL_LAT = 24,
`ifdef ALU_CTRL_DIV_EN
  parameter int DIV_LAT = 26,
`endif
  parameter int CNT_W   = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [1:0]         ALUOp,
  input  logic [FUNCT_W-1:0] Funct,
  output logic [CTRL_W-1:0]  ALUCtrl,
  output logic               ctrl_valid,
  output logic               mul_start,
`ifdef ALU_CTRL_DIV_EN
  output logic               div_start,
`endif
  output logic               stall,
  output logic               op_done,
  output logic               illegal_op
);

  localparam logic [CTRL_W-1:0] CODE_AND = CTRL_W'(4'b0000);
  localparam logic [CTRL_W-1:0] CODE_OR  = CTRL_W'(4'b0001);
  localparam logic [CTRL_W-1:0] CODE_ADD = CTRL_W'(4'b0010);
  localparam logic [CTRL_W-1:0] CODE_SLT = CTRL_W'(4'b0011);
  localparam logic [CTRL_W-1:0] CODE_MUL = CTRL_W'(4'b0100);
  localparam logic [CTRL_W-1:0] CODE_XOR = CTRL_W'(4'b0101);
  localparam logic [CTRL_W-1:0] CODE_BNE = CTRL_W'(4'b0110);
  localparam logic [CTRL_W-1:0] CODE_SLL = CTRL_W'(4'b0110);
  localparam logic [CTRL_W-1:0] CODE_SUB = CTRL_W'(4'b1010);
  localparam logic [CTRL_W-1:0] CODE_NOP = CTRL_W'(4'b1111);
`ifdef ALU_CTRL_DIV_EN
  localparam logic [CTRL_W-1:0] CODE_DIV = CTRL_W'(4'b0111);
`endif

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXEC     = 2'd1,
    MUL_BUSY = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [CTRL_W-1:0] dec_code;
  logic              dec_illegal;
  logic              dec_multi;
  logic              dec_div;
  logic [CNT_W-1:0]  dec_load;
  logic              accept;

  assign accept = op_valid && op_ready;

  // Every path assigns all decode outputs, so no stale code can be held combinationally.
  always_comb begin
    dec_code    = CODE_NOP;
    dec_illegal = 1'b1;
    dec_multi   = 1'b0;
    dec_div     = 1'b0;
    dec_load    = CNT_W'(MUL_LAT - 1);
    case (ALUOp)
      2'b00: begin dec_code = CODE_ADD; dec_illegal = 1'b0; end
      2'b01: begin dec_code = CODE_BNE; dec_illegal = 1'b0; end
      2'b10: begin
        dec_illegal = 1'b0;
        case (Funct)
          FUNCT_W'(0): dec_code = CODE_AND;
          FUNCT_W'(1): dec_code = CODE_OR;
          FUNCT_W'(2): dec_code = CODE_ADD;
          FUNCT_W'(3): dec_code = CODE_SUB;
          FUNCT_W'(4): dec_code = CODE_SLT;
          FUNCT_W'(5): begin dec_code = CODE_MUL; dec_multi = 1'b1; end
          FUNCT_W'(6): dec_code = CODE_XOR;
          FUNCT_W'(7): dec_code = CODE_SLL;
`ifdef ALU_CTRL_DIV_EN
          FUNCT_W'(8): begin
            dec_code  = CODE_DIV;
            dec_multi = 1'b1;
            dec_div   = 1'b1;
            dec_load  = CNT_W'(DIV_LAT - 1);
          end
`endif
          default: dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ALUCtrl    <= CODE_NOP;
      cnt        <= '0;
      op_ready   <= 1'b1;
      ctrl_valid <= 1'b0;
      mul_start  <= 1'b0;
`ifdef ALU_CTRL_DIV_EN
      div_start  <= 1'b0;
`endif
      stall      <= 1'b0;
      op_done    <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      mul_start  <= 1'b0;
`ifdef ALU_CTRL_DIV_EN
      div_start  <= 1'b0;
`endif
      op_done    <= 1'b0;
      illegal_op <= 1'b0;
      case (state)
        IDLE, EXEC: begin
          if (accept) begin
            ALUCtrl <= dec_code;
            if (dec_multi) begin
              state      <= MUL_BUSY;
              op_ready   <= 1'b0;
              stall      <= 1'b1;
              ctrl_valid <= 1'b1;
              mul_start  <= !dec_div;
`ifdef ALU_CTRL_DIV_EN
              div_start  <= dec_div;
`endif
              cnt        <= dec_load;
            end else begin
              state      <= EXEC;
              ctrl_valid <= !dec_illegal;
              op_done    <= 1'b1;
              illegal_op <= dec_illegal;
            end
          end else begin
            state      <= IDLE;
            ctrl_valid <= 1'b0;
          end
        end
        MUL_BUSY: begin
          // op_done lands on the last stall cycle; the exit edge only releases the pipeline.
          if (cnt == '0) begin
            state      <= IDLE;
            stall      <= 1'b0;
            ctrl_valid <= 1'b0;
            op_ready   <= 1'b1;
          end else begin
            cnt     <= cnt - CNT_W'(1);
            op_done <= (cnt == CNT_W'(1));
          end
        end
        default: begin
          state    <= IDLE;
          stall    <= 1'b0;
          op_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_seq.sv
`default_nettype none
// tb_alu_ctrl_seq: vector table, directed multi-cycle sequences and random ops vs. a cycle-count model.
module tb_alu_ctrl_seq;

  localparam int MUL_LAT = 24;
  localparam int DIV_LAT = 26;
  localparam logic [3:0] R_CODES [0:7] = '{4'b0000, 4'b0001, 4'b0010, 4'b1010,
                                          4'b0011, 4'b0100, 4'b0101, 4'b0110};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       op_valid = 1'b0;
  logic [1:0] ALUOp = 2'b00;
  logic [3:0] Funct = 4'b0000;
  logic       op_ready, ctrl_valid, mul_start, stall, op_done, illegal_op;
  logic [3:0] ALUCtrl;
`ifdef ALU_CTRL_DIV_EN
  logic       div_start;
`endif

  int checks = 0;
  int failures = 0;

  // Model state: remaining stall cycles instead of an FSM encoding.
  bit         m_ready, m_cv, m_mstart, m_dstart, m_stall, m_done, m_ill;
  logic [3:0] m_code;
  int         m_busy;

  alu_ctrl_seq #(
    .FUNCT_W(4),
    .CTRL_W (4),
    .MUL_LAT(MUL_LAT),
`ifdef ALU_CTRL_DIV_EN
    .DIV_LAT(DIV_LAT),
`endif
    .CNT_W  (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .ALUOp     (ALUOp),
    .Funct     (Funct),
    .ALUCtrl   (ALUCtrl),
    .ctrl_valid(ctrl_valid),
    .mul_start (mul_start),
`ifdef ALU_CTRL_DIV_EN
    .div_start (div_start),
`endif
    .stall     (stall),
    .op_done   (op_done),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void ref_decode(input logic [1:0] op, input logic [3:0] f,
                                     output logic [3:0] code, output bit ill,
                                     output int lat, output bit is_div);
    code = 4'hF; ill = 1'b1; lat = 0; is_div = 1'b0;
    if (op == 2'b00) begin
      code = 4'b0010; ill = 1'b0;
    end else if (op == 2'b01) begin
      code = 4'b0110; ill = 1'b0;
    end else if (op == 2'b10) begin
      if (f < 4'd8) begin
        code = R_CODES[f[2:0]];
        ill  = 1'b0;
        if (f == 4'd5) lat = MUL_LAT;
      end
`ifdef ALU_CTRL_DIV_EN
      else if (f == 4'd8) begin
        code = 4'b0111; ill = 1'b0; lat = DIV_LAT; is_div = 1'b1;
      end
`endif
    end
  endfunction

  task automatic model_reset();
    m_ready = 1'b1; m_cv = 1'b0; m_mstart = 1'b0; m_dstart = 1'b0;
    m_stall = 1'b0; m_done = 1'b0; m_ill = 1'b0; m_code = 4'hF; m_busy = 0;
  endtask

  task automatic model_step(input bit v, input logic [1:0] op, input logic [3:0] f);
    logic [3:0] code;
    bit ill, is_div;
    int lat;
    m_mstart = 1'b0; m_dstart = 1'b0; m_done = 1'b0; m_ill = 1'b0;
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 1) m_done = 1'b1;
      if (m_busy == 0) begin m_stall = 1'b0; m_cv = 1'b0; m_ready = 1'b1; end
    end else if (v && m_ready) begin
      ref_decode(op, f, code, ill, lat, is_div);
      m_code = code;
      if (lat > 0) begin
        m_busy = lat; m_stall = 1'b1; m_cv = 1'b1; m_ready = 1'b0;
        if (is_div) m_dstart = 1'b1; else m_mstart = 1'b1;
      end else begin
        m_cv = !ill; m_done = 1'b1; m_ill = ill;
      end
    end else begin
      m_cv = 1'b0;
    end
  endtask

  task automatic compare_all(input string name);
    logic dstart;
`ifdef ALU_CTRL_DIV_EN
    dstart = div_start;
`else
    dstart = 1'b0;
`endif
    check(name,
          32'({op_ready, ctrl_valid, mul_start, dstart, stall, op_done, illegal_op, ALUCtrl}),
          32'({m_ready, m_cv, m_mstart, m_dstart, m_stall, m_done, m_ill, m_code}));
  endtask

  task automatic tick();
    bit         v  = op_valid;
    logic [1:0] op = ALUOp;
    logic [3:0] f  = Funct;
    @(posedge clk);
    model_step(v, op, f);
    #1;
    compare_all("model");
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    op_valid = 1'b0;
    #1;
    model_reset();
    compare_all("reset_async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    compare_all("reset_release");
  endtask

  task automatic measure_multi(output int len, output int done_at, output int rdy_bad);
    len     = stall ? 1 : 0;
    done_at = op_done ? 1 : 0;
    rdy_bad = op_ready ? 1 : 0;
    for (int i = 0; i < 80 && stall; i++) begin
      tick();
      if (stall) begin
        len++;
        if (op_done) done_at = len;
        if (op_ready) rdy_bad++;
      end
    end
  endtask

  typedef struct {
    bit         v;
    logic [1:0] op;
    logic [3:0] f;
    logic [3:0] code;
    bit         cv;
    bit         done;
    bit         ill;
  } vec_t;

  vec_t vecs[$];
  int   len, done_at, rdy_bad;

  initial begin
    vecs.push_back('{1'b1, 2'b10, 4'd0,  4'b0000, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 2'b10, 4'd3,  4'b1010, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 2'b10, 4'd7,  4'b0110, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 2'b10, 4'd1,  4'b0001, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 2'b10, 4'd2,  4'b0010, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 2'b10, 4'd4,  4'b0011, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 2'b10, 4'd6,  4'b0101, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 2'b00, 4'd9,  4'b0010, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 2'b01, 4'd3,  4'b0110, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 2'b10, 4'd0,  4'b0110, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 2'b11, 4'd0,  4'b1111, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 2'b10, 4'd10, 4'b1111, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 2'b10, 4'd15, 4'b1111, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 2'b00, 4'd0,  4'b1111, 1'b0, 1'b0, 1'b0});

    model_reset();
    repeat (2) @(negedge clk);
    compare_all("reset_initial");
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      op_valid = vecs[i].v; ALUOp = vecs[i].op; Funct = vecs[i].f;
      tick();
      check($sformatf("vec%0d_code", i), 32'(ALUCtrl), 32'(vecs[i].code));
      check($sformatf("vec%0d_flags", i), 32'({ctrl_valid, op_done, illegal_op, stall}),
            32'({vecs[i].cv, vecs[i].done, vecs[i].ill, 1'b0}));
    end

    // MUL with an ADD held pending until op_ready returns.
    op_valid = 1'b1; ALUOp = 2'b10; Funct = 4'd5;
    tick();
    check("mul_start_cycle", 32'({mul_start, stall, op_ready, ALUCtrl}), 32'({3'b110, 4'b0100}));
    ALUOp = 2'b00; Funct = 4'd0;
    measure_multi(len, done_at, rdy_bad);
    check("mul_stall_len", 32'(len), 32'(MUL_LAT));
    check("mul_done_cycle", 32'(done_at), 32'(MUL_LAT));
    check("mul_ready_low", 32'(rdy_bad), 32'(0));
    check("mul_held_code", 32'({op_ready, op_done, ALUCtrl}), 32'({2'b10, 4'b0100}));
    tick();
    check("add_after_mul", 32'({ctrl_valid, op_done, ALUCtrl}), 32'({2'b11, 4'b0010}));
    op_valid = 1'b0;
    tick();

    // Funct 1000: DIV when enabled, illegal otherwise.
    op_valid = 1'b1; ALUOp = 2'b10; Funct = 4'd8;
    tick();
    op_valid = 1'b0;
`ifdef ALU_CTRL_DIV_EN
    check("div_start_cycle", 32'({div_start, mul_start, stall, ALUCtrl}), 32'({3'b101, 4'b0111}));
    measure_multi(len, done_at, rdy_bad);
    check("div_stall_len", 32'(len), 32'(DIV_LAT));
    check("div_done_cycle", 32'(done_at), 32'(DIV_LAT));
`else
    check("funct8_illegal", 32'({illegal_op, ctrl_valid, stall, ALUCtrl}), 32'({3'b100, 4'b1111}));
`endif
    tick();

    // Reset during cycle 10 of a MUL aborts without op_done.
    op_valid = 1'b1; ALUOp = 2'b10; Funct = 4'd5;
    tick();
    op_valid = 1'b0;
    repeat (9) tick();
    check("abort_precond", 32'(stall), 32'(1));
    do_reset();
    check("abort_outputs", 32'({stall, op_done, mul_start, ctrl_valid, ALUCtrl}), 32'({4'b0000, 4'b1111}));
    done_at = 0;
    for (int i = 0; i < MUL_LAT + 4; i++) begin
      tick();
      if (op_done) done_at++;
    end
    check("abort_no_done", 32'(done_at), 32'(0));
    op_valid = 1'b1; ALUOp = 2'b00; Funct = 4'd0;
    tick();
    check("lw_after_abort", 32'({ctrl_valid, op_done, ALUCtrl}), 32'({2'b11, 4'b0010}));
    op_valid = 1'b0;
    tick();

    // Random traffic against the model, with one asynchronous reset mid-run.
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_reset();
      op_valid = ($urandom_range(0, 9) < 7);
      ALUOp    = 2'($urandom);
      Funct    = ($urandom_range(0, 3) == 0) ? 4'd5 : 4'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
